ahb_cache_arbiter: RTL
======================

// Module: ahb_cache_arbiter
// PURPOSE
//  Shares the single AHB master port between the instruction cache (m0) and the data cache (m1).
//  Each cache drives a complete AHB master i/f (sel/htrans/haddr/...); the arbiter grants one per burst.
//  Non-granted masters see hready_out=0 and stall. Sits between the cache pair and the AHB interconnect.
// PARAMETERS
//  FIXED_PRIO   0  0: round-robin between m0/m1; 1: m1 (DCache) always wins simultaneous requests
//  HOLD_LIMIT   64 max consecutive cycles one master may hold grant before hold_timeout pulses (debug only)
// PORTS
//  clk              in   1   clock
//  rst              in   1   synchronous reset, active-high
//  mN_sel           in   1   (N=0,1) master requests/holds bus
//  mN_htrans        in   2   master transfer type
//  mN_haddr         in   32  master address
//  mN_hburst/hsize  in   3/3 master burst/size
//  mN_hprot         in   4   master protection
//  mN_hwrite        in   1   master write
//  mN_hwdata        in   32  master write data (data phase)
//  mN_hready_out    out  1   per-master ready: bus hready_out if granted, else 0
//  mN_hrdata        out  32  bus hrdata, broadcast
//  mN_hresp         out  1   bus hresp if data-phase owner, else 0
//  AHB_sel/htrans/haddr/hburst/hsize/hprot/hwrite/hwdata  out  muxed bus master signals
//  AHB_hready_in    out  1   = AHB_hready_out
//  AHB_hrdata/hready_out/hresp  in  bus slave responses
//  grant            out  2   one-hot current owner {m1,m0}; 2'b00 = none
//  hold_timeout     out  1   one-cycle pulse when owner reaches HOLD_LIMIT cycles
// BEHAVIOUR
//  Reset (rst=1 @ posedge): grant=00, dphase_owner=none, last=m1 (m0 wins first RR), hold_cnt=0,
//   hold_timeout=0; AHB_sel=0, AHB_htrans=IDLE, AHB_hwrite=0, all mN_hready_out=0.
//  FSM: IDLE, OWN0, OWN1 (grant is the registered state).
//   IDLE: m0_sel|m1_sel -> OWN0/OWN1 next cycle; both: FIXED_PRIO=1 -> OWN1, else the one != last.
//   OWNn: stay while mn_sel=1. On mn_sel=0 and AHB_hready_out=1 -> release: last<=n;
//    if other sel=1 -> OWN(other) same edge (no IDLE bubble); else IDLE.
//   A pending request never preempts a burst; release only on owner's sel=0.
//  Latency: request in cycle t -> grant at t+1; owner's NONSEQ on bus in t+1.
//  Address-phase mux: by grant; grant=00 -> AHB_sel=0, htrans=IDLE, others 0.
//  Data phase: dphase_owner <= grant when AHB_hready_out=1; hwdata and hresp routed by dphase_owner.
//  Ungranted master's htrans/sel never reach the bus even if NONSEQ.
//  hold_cnt: clears on grant change, +1 per owned cycle, saturates at HOLD_LIMIT;
//   hold_timeout=1 exactly on the cycle it reaches HOLD_LIMIT. No effect on arbitration.
//  hready low during release cycle: release deferred until hready=1.
//  Reset mid-burst: grant drops to 00 next edge; bus htrans IDLE; caches are reset by same rst.
// STRUCTURE
//  Shared package: AHB_IDLE/BUSY/NONSEQ/SEQ htrans constants, arbiter state encoding.
//  Single module; no sub-module (mux + 3-state FSM + counter). Target ~150-200 lines.
// TESTING
//  1 Reset: rst=1 two cycles -> grant=00, AHB_htrans=IDLE, AHB_sel=0, m0/m1_hready_out=0.
//  2 Solo m0 16-beat read @0x00001000: m0_sel=1 t0 -> grant=01 t1, AHB_haddr=0x1000 t1; 16 words
//    to m0_hrdata; m0_sel=0 -> grant=00 next edge.
//  3 Simultaneous m0_sel,m1_sel, FIXED_PRIO=0, after reset -> m0 first; on m0 release, grant=10 same
//    edge, no IDLE cycle; repeat -> m1 first (alternation).
//  4 m1 request mid m0 burst (beat 5): m1_hready_out stays 0, m1 NONSEQ absent from bus until m0_sel=0.
//  5 Release with AHB_hready_out=0 (wait-state slave): grant held until hready=1; hwdata/hresp from prior owner.
//  6 rst asserted at beat 8 of m1 write burst -> next cycle grant=00, AHB_htrans=IDLE; HOLD_LIMIT=4
//    run -> hold_timeout single pulse on 4th owned cycle.

Source files
------------

// File: rtl/ahb_cache_arbiter_pkg.sv
// Shared definitions for the I/D-cache AHB arbiter: AHB transfer types and
// the arbiter state encoding. The owned states are one-hot {m1,m0}, so the
// state register doubles as the grant vector.
package ahb_cache_arbiter_pkg;

    localparam logic [1:0] AHB_IDLE   = 2'b00;
    localparam logic [1:0] AHB_BUSY   = 2'b01;
    localparam logic [1:0] AHB_NONSEQ = 2'b10;
    localparam logic [1:0] AHB_SEQ    = 2'b11;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'b00,
        ARB_OWN0 = 2'b01,
        ARB_OWN1 = 2'b10
    } arb_state_t;

endpackage

// File: rtl/ahb_cache_arbiter.sv
// Two-master AHB arbiter: the instruction cache (m0) and data cache (m1)
// share one AHB master port. Grant is held for a whole burst and only
// released when the owner drops sel while the bus is ready.
module ahb_cache_arbiter
    import ahb_cache_arbiter_pkg::*;
#(
    parameter int FIXED_PRIO = 0,
    parameter int HOLD_LIMIT = 64
) (
    input  logic        clk,
    input  logic        rst,
    // master 0 (instruction cache)
    input  logic        m0_sel,
    input  logic [1:0]  m0_htrans,
    input  logic [31:0] m0_haddr,
    input  logic [2:0]  m0_hburst,
    input  logic [2:0]  m0_hsize,
    input  logic [3:0]  m0_hprot,
    input  logic        m0_hwrite,
    input  logic [31:0] m0_hwdata,
    output logic        m0_hready_out,
    output logic [31:0] m0_hrdata,
    output logic        m0_hresp,
    // master 1 (data cache)
    input  logic        m1_sel,
    input  logic [1:0]  m1_htrans,
    input  logic [31:0] m1_haddr,
    input  logic [2:0]  m1_hburst,
    input  logic [2:0]  m1_hsize,
    input  logic [3:0]  m1_hprot,
    input  logic        m1_hwrite,
    input  logic [31:0] m1_hwdata,
    output logic        m1_hready_out,
    output logic [31:0] m1_hrdata,
    output logic        m1_hresp,
    // shared AHB master port
    output logic        AHB_sel,
    output logic [1:0]  AHB_htrans,
    output logic [31:0] AHB_haddr,
    output logic [2:0]  AHB_hburst,
    output logic [2:0]  AHB_hsize,
    output logic [3:0]  AHB_hprot,
    output logic        AHB_hwrite,
    output logic [31:0] AHB_hwdata,
    output logic        AHB_hready_in,
    input  logic [31:0] AHB_hrdata,
    input  logic        AHB_hready_out,
    input  logic        AHB_hresp,
    // status
    output logic [1:0]  grant,
    output logic        hold_timeout
);

    localparam int               CNT_W     = $clog2(HOLD_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_VAL = CNT_W'(HOLD_LIMIT);

    arb_state_t       state, state_nxt;
    logic             last_m1, last_m1_nxt;   // 1: m1 was the last owner to release
    logic [1:0]       dphase_owner;           // one-hot owner of the current data phase
    logic [CNT_W-1:0] hold_cnt, hold_cnt_nxt;
    logic             grant_change;

    // Next owner: new grants only from IDLE, hand-over only on the owner's release
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt   = state;
        last_m1_nxt = last_m1;
        case (state)
            ARB_IDLE: begin
                if (m0_sel && m1_sel)
                    state_nxt = (FIXED_PRIO != 0 || !last_m1) ? ARB_OWN1 : ARB_OWN0;
                else if (m0_sel)
                    state_nxt = ARB_OWN0;
                else if (m1_sel)
                    state_nxt = ARB_OWN1;
            end
            ARB_OWN0: begin
                if (!m0_sel && AHB_hready_out) begin
                    last_m1_nxt = 1'b0;
                    state_nxt   = m1_sel ? ARB_OWN1 : ARB_IDLE;
                end
            end
            ARB_OWN1: begin
                if (!m1_sel && AHB_hready_out) begin
                    last_m1_nxt = 1'b1;
                    state_nxt   = m0_sel ? ARB_OWN0 : ARB_IDLE;
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    // Arbiter state and round-robin pointer; last=m1 after reset so m0 wins first
    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ARB_IDLE;
            last_m1 <= 1'b1;
        end else begin
            state   <= state_nxt;
            last_m1 <= last_m1_nxt;
        end
    end

    assign grant = state;

    // Data phase follows the address phase that the bus just accepted
    always_ff @(posedge clk) begin
        if (rst)
            dphase_owner <= 2'b00;
        else if (AHB_hready_out)
            dphase_owner <= grant;
    end

    // Ownership length counter: 1 on the first owned cycle, saturating at the limit
    assign grant_change = (state_nxt != state);

    always_comb begin
        hold_cnt_nxt = hold_cnt;
        if (grant_change)
            hold_cnt_nxt = (state_nxt != ARB_IDLE) ? CNT_W'(1) : '0;
        else if (state != ARB_IDLE && hold_cnt != LIMIT_VAL)
            hold_cnt_nxt = hold_cnt + CNT_W'(1);
    end

    // Debug pulse in the owned cycle whose count first equals the limit
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt     <= '0;
            hold_timeout <= 1'b0;
        end else begin
            hold_cnt     <= hold_cnt_nxt;
            hold_timeout <= (hold_cnt_nxt == LIMIT_VAL) && (grant_change || hold_cnt != LIMIT_VAL);
        end
    end

    // Address-phase mux by grant; an ungranted master never reaches the bus
    always_comb begin
        AHB_sel    = 1'b0;
        AHB_htrans = AHB_IDLE;
        AHB_haddr  = '0;
        AHB_hburst = '0;
        AHB_hsize  = '0;
        AHB_hprot  = '0;
        AHB_hwrite = 1'b0;
        case (state)
            ARB_OWN0: begin
                AHB_sel    = m0_sel;
                AHB_htrans = m0_htrans;
                AHB_haddr  = m0_haddr;
                AHB_hburst = m0_hburst;
                AHB_hsize  = m0_hsize;
                AHB_hprot  = m0_hprot;
                AHB_hwrite = m0_hwrite;
            end
            ARB_OWN1: begin
                AHB_sel    = m1_sel;
                AHB_htrans = m1_htrans;
                AHB_haddr  = m1_haddr;
                AHB_hburst = m1_hburst;
                AHB_hsize  = m1_hsize;
                AHB_hprot  = m1_hprot;
                AHB_hwrite = m1_hwrite;
            end
            default: ;
        endcase
    end

    // Data-phase routing by data-phase owner
    always_comb begin
        case (dphase_owner)
            2'b01:   AHB_hwdata = m0_hwdata;
            2'b10:   AHB_hwdata = m1_hwdata;
            default: AHB_hwdata = '0;
        endcase
    end

    assign m0_hresp      = dphase_owner[0] & AHB_hresp;
    assign m1_hresp      = dphase_owner[1] & AHB_hresp;
    assign m0_hready_out = grant[0] & AHB_hready_out;
    assign m1_hready_out = grant[1] & AHB_hready_out;
    assign m0_hrdata     = AHB_hrdata;
    assign m1_hrdata     = AHB_hrdata;
    assign AHB_hready_in = AHB_hready_out;

endmodule
